// File: rtl/dst_pkg.sv
// Shared widths, word layout and output-FSM states for the destination stream FIFO.
package dst_pkg;

   localparam int DST_DATA_W = 64;
   localparam int DST_DEPTH  = 32;
   localparam int DST_ADDR_W = 5;

   typedef struct packed {
      logic                    last;
      logic [DST_DATA_W/8-1:0] strb;
      logic [DST_DATA_W-1:0]   data;
   } dst_word_t;

   typedef enum logic {
      OUT_IDLE = 1'b0,
      OUT_PKT  = 1'b1
   } out_state_t;

endpackage

// File: rtl/dst_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read so the head word
// is visible in the same cycle its read address is presented (first-word fall-through).
module dst_fifo_ram
   import dst_pkg::*;
#(
   parameter int WIDTH  = DST_DATA_W + DST_DATA_W/8 + 1,
   parameter int DEPTH  = DST_DEPTH,
   parameter int ADDR_W = DST_ADDR_W
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [WIDTH-1:0]  wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [WIDTH-1:0]  rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dst_stream_fifo.sv
// Result-stream FIFO in front of the S2MM DMA: absorbs back-pressure, counts
// TLAST-delimited packets and optionally holds packets back until complete.
module dst_stream_fifo
   import dst_pkg::*;
#(
   parameter int DATA_W = DST_DATA_W,
   parameter int DEPTH  = DST_DEPTH,
   parameter int ADDR_W = DST_ADDR_W
) (
   input  logic                AXIS_ACLK,
   input  logic                AXIS_ARESETN,
   input  logic                clr,
   input  logic                sf_mode,
   input  logic                S_AXIS_TVALID,
   input  logic [DATA_W-1:0]   S_AXIS_TDATA,
   input  logic [DATA_W/8-1:0] S_AXIS_TSTRB,
   input  logic                S_AXIS_TLAST,
   output logic                S_AXIS_TREADY,
   output logic                M_AXIS_TVALID,
   output logic [DATA_W-1:0]   M_AXIS_TDATA,
   output logic [DATA_W/8-1:0] M_AXIS_TSTRB,
   output logic                M_AXIS_TLAST,
   input  logic                M_AXIS_TREADY,
   output logic [ADDR_W:0]     level,
   output logic [ADDR_W:0]     pkt_cnt,
   output logic                oversize,
   output logic                dbg_state_o
);

   localparam int              WORD_W   = DATA_W + DATA_W/8 + 1;
   localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

   // Reset asserts asynchronously and releases on a clock edge.
   logic rst_meta_q;
   logic rst_sync_q;
   logic rst_n;

   always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
      if (!AXIS_ARESETN) begin
         rst_meta_q <= 1'b0;
         rst_sync_q <= 1'b0;
      end else begin
         rst_meta_q <= 1'b1;
         rst_sync_q <= rst_meta_q;
      end
   end

   assign rst_n = rst_sync_q;

   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic [ADDR_W-1:0] rptr_q, rptr_d;
   logic [ADDR_W:0]   level_q, level_d;
   logic [ADDR_W:0]   pkt_q, pkt_d;
   logic              oversize_q, oversize_d;
   out_state_t        state_q, state_d;

   logic              full;
   logic              empty;
   logic              pkt_none;
   logic              force_out;
   logic              s_ready;
   logic              m_valid;
   logic              push;
   logic              pop;
   logic [WORD_W-1:0] wr_word;
   logic [WORD_W-1:0] rd_word;

   // Handshake: a beat transfers on a side exactly when its VALID and READY are both
   // high at the clock edge. READY here depends only on registered state and clr, and
   // VALID never drops without a transfer, so neither side can retract a beat.
   assign full      = (level_q == FULL_LVL);
   assign empty     = (level_q == '0);
   assign pkt_none  = (pkt_q == '0);
   assign force_out = sf_mode & full & pkt_none;

   assign s_ready = rst_n & ~full & ~clr;
   assign m_valid = (state_q == OUT_PKT) ? ~empty
                                         : ~empty & (~sf_mode | ~pkt_none | force_out);

   assign push = S_AXIS_TVALID & s_ready;
   assign pop  = m_valid & M_AXIS_TREADY;

   assign wr_word = {S_AXIS_TLAST, S_AXIS_TSTRB, S_AXIS_TDATA};
   assign {M_AXIS_TLAST, M_AXIS_TSTRB, M_AXIS_TDATA} = rd_word;

   dst_fifo_ram #(
      .WIDTH  (WORD_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk_i   (AXIS_ACLK),
      .we_i    (push),
      .waddr_i (wptr_q),
      .wdata_i (wr_word),
      .raddr_i (rptr_q),
      .rdata_o (rd_word)
   );

   // sf_mode only gates VALID in OUT_IDLE, i.e. at a packet boundary.
   always_comb begin
      state_d    = state_q;
      oversize_d = oversize_q;
      case (state_q)
         OUT_IDLE: begin
            if (force_out) begin
               oversize_d = 1'b1;
            end
            if (pop && !M_AXIS_TLAST) begin
               state_d = OUT_PKT;
            end
         end
         OUT_PKT: begin
            if (pop && M_AXIS_TLAST) begin
               state_d = OUT_IDLE;
            end
         end
         default: state_d = OUT_IDLE;
      endcase
      if (clr) begin
         state_d    = OUT_IDLE;
         oversize_d = 1'b0;
      end
   end

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      pkt_d   = pkt_q;
      if (push) begin
         wptr_d = wptr_q + PTR_ONE;
      end
      if (pop) begin
         rptr_d = rptr_q + PTR_ONE;
      end
      case ({push, pop})
         2'b10:   level_d = level_q + CNT_ONE;
         2'b01:   level_d = level_q - CNT_ONE;
         default: level_d = level_q;
      endcase
      case ({push & S_AXIS_TLAST, pop & M_AXIS_TLAST})
         2'b10:   pkt_d = pkt_q + CNT_ONE;
         2'b01:   pkt_d = pkt_q - CNT_ONE;
         default: pkt_d = pkt_q;
      endcase
      if (clr) begin
         wptr_d  = '0;
         rptr_d  = '0;
         level_d = '0;
         pkt_d   = '0;
      end
   end

   always_ff @(posedge AXIS_ACLK or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         level_q    <= '0;
         pkt_q      <= '0;
         oversize_q <= 1'b0;
         state_q    <= OUT_IDLE;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         level_q    <= level_d;
         pkt_q      <= pkt_d;
         oversize_q <= oversize_d;
         state_q    <= state_d;
      end
   end

   assign S_AXIS_TREADY = s_ready;
   assign M_AXIS_TVALID = m_valid;
   assign level         = level_q;
   assign pkt_cnt       = pkt_q;
   assign oversize      = oversize_q;
   assign dbg_state_o   = state_q;

endmodule

// File: doc/dst_stream_fifo.md
Name: dst_stream_fifo

Overview:
- Buffers the accelerator's 64-bit result stream (dst_ctrl/dst_buf output, M_AXIS_* of top) before the S2MM DMA channel.
- Absorbs DMA back-pressure so dst_buf can drain.
- Counts whole packets (TLAST-delimited).
- Optionally operates store-and-forward, so the DMA only sees a packet once it is complete.

Parameters:
- DATA_W, 64, stream data width (TSTRB width = DATA_W/8).
- DEPTH, 32, FIFO entries; power of two, >= 4.
- ADDR_W, 5, log2(DEPTH).

Ports:
- AXIS_ACLK in 1: single clock.
- AXIS_ARESETN in 1: reset, asynchronous, active-low.
- clr in 1: synchronous clear; top drives it with ~run.
- sf_mode in 1: 1 = store-and-forward, 0 = cut-through.
- S_AXIS_TVALID in 1: upstream valid (from top M_AXIS_TVALID).
- S_AXIS_TDATA in DATA_W: upstream data.
- S_AXIS_TSTRB in DATA_W/8: upstream byte strobe; stored with the data.
- S_AXIS_TLAST in 1: upstream end of packet.
- S_AXIS_TREADY out 1: space available.
- M_AXIS_TVALID out 1: downstream valid.
- M_AXIS_TDATA out DATA_W: downstream data.
- M_AXIS_TSTRB out DATA_W/8: downstream strobe.
- M_AXIS_TLAST out 1: downstream end of packet.
- M_AXIS_TREADY in 1: DMA ready.
- level out ADDR_W+1: entries currently held, 0..DEPTH.
- pkt_cnt out ADDR_W+1: complete packets (TLAST written) not yet fully read.
- oversize out 1: sticky; a packet longer than DEPTH was forced out in store-and-forward mode.

Behaviour:
- Reset (AXIS_ARESETN=0, async): pointers=0, level=0, pkt_cnt=0, oversize=0, out_active=0, M_AXIS_TVALID=0, S_AXIS_TREADY=0 while reset is asserted.
- Reset is released synchronously to AXIS_ACLK internally.
- Push: S_AXIS_TVALID & S_AXIS_TREADY. Stores {TLAST,TSTRB,TDATA} at wptr; wptr wraps modulo DEPTH.
- S_AXIS_TREADY = (level != DEPTH) & ~clr. It is driven from registered state only, with no combinational path from M_AXIS_TREADY.
- Pop: M_AXIS_TVALID & M_AXIS_TREADY. Advances rptr with modulo wrap.
- M_AXIS_TDATA/TSTRB/TLAST always reflect the entry at rptr (first-word fall-through). They are stable while TVALID=1 and TREADY=0.
- Latency: a word pushed in cycle N is presentable at the M side in cycle N+1 at the earliest (cut-through, empty FIFO).
- level: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- When full, TREADY=0, so no push occurs even if a pop happens that cycle (no full bypass).
- When empty, TVALID=0, so no pop occurs.
- pkt_cnt: +1 on a push with TLAST=1, -1 on a pop with TLAST=1, unchanged if both occur in the same cycle.
- Output state machine, OUT_IDLE:
  - TVALID = (level!=0) & (~sf_mode | pkt_cnt!=0 | force).
  - force = sf_mode & (level==DEPTH) & (pkt_cnt==0).
  - When force applies, set oversize=1.
  - On the first pop of a word with TLAST=0, go to OUT_PKT.
  - A single-word packet (TLAST=1 on first pop) stays in OUT_IDLE.
- Output state machine, OUT_PKT:
  - TVALID = (level!=0), ignoring sf_mode.
  - On a pop with TLAST=1, go to OUT_IDLE.
  - sf_mode is therefore only sampled at packet boundaries.
- AXIS rule: once TVALID=1 it stays 1 until the pop. Both state equations guarantee this, because nothing decrements level or pkt_cnt without a pop.
- clr=1 (synchronous, dominant over push/pop in that cycle): pointers, level, pkt_cnt, out_active and oversize return to 0 on the next edge. M_AXIS_TVALID=0 from the next cycle. Memory contents are don't-care.
- Asynchronous reset mid-packet: all state is lost. The DMA must be reset alongside; no recovery of partial packets.
- Upstream TSTRB is stored unmodified (top drives 8'hff). No packing or width conversion.

Decomposition:
- Shared package dst_pkg:
  - DST_DATA_W=64, DST_DEPTH=32, DST_ADDR_W=5.
  - Typedef dst_word_t = struct {last, strb[7:0], data[63:0]}.
  - Enum out_state_t {OUT_IDLE, OUT_PKT}.
- Sub-module dst_fifo_ram: simple dual-port memory, DEPTH x (DATA_W+DATA_W/8+1).
  - Synchronous write.
  - Asynchronous read of rptr, for FWFT; LUTRAM-mappable.
- The top-level module keeps pointers, counters, the FSM and the handshake logic.

Test Plan:
- Cut-through, M_AXIS_TREADY=1: push 4 words 0x1..0x4, TLAST on 0x4 → each appears the cycle after push. TLAST only with 0x4. level returns to 0, pkt_cnt pulses 1 then 0.
- Back-pressure, TREADY=0: push 33 attempts → 32 accepted, S_AXIS_TREADY=0 at level=32. Raise TREADY → 32 words out in order with pointer wrap; level=0.
- Store-and-forward, sf_mode=1: push 3 words, TLAST on word 3, one idle cycle between each → TVALID stays 0 until the cycle after the TLAST push, then 3 back-to-back pops.
- Oversize: sf_mode=1, TREADY=1, 40-word packet → TVALID rises when level=32, oversize=1 sticky. All 40 words delivered, TLAST on word 40.
- Simultaneous push/pop at level=5 with TLAST on both words → level stays 5, pkt_cnt unchanged.
- Mid-packet: assert clr for 1 cycle with level=7 → level=0, pkt_cnt=0, TVALID=0 next cycle. Pulse AXIS_ARESETN low between edges → outputs reset immediately (async).
